// File: rtl/mmd_minmax_scan.sv
// mmd_minmax_scan: sequential min/max scan over a local operand store.
// Walks rd_addr from 0 to len, tracks the running maximum and minimum of
// rd_data, and registers their difference when the scan completes.
// Optional build macro: MMD_SIGNED_EN selects two's-complement compares and a
// widened, saturating difference; when undefined, compares are unsigned.
module mmd_minmax_scan #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_q,
    output logic [DATA_W-1:0] min_q,
    output logic [DATA_W-1:0] diff_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SCAN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] max_nxt;
    logic [DATA_W-1:0] min_nxt;
    logic [DATA_W-1:0] diff_nxt;
    logic              gt_max;
    logic              lt_min;

`ifdef MMD_SIGNED_EN
    logic signed [DATA_W:0] diff_wide;

    // Two's-complement compares against the running extremes.
    assign gt_max = $signed(rd_data) > $signed(max_q);
    assign lt_min = $signed(rd_data) < $signed(min_q);

    // Sign-extend both extremes so the subtraction cannot wrap, then clamp
    // anything outside the unsigned DATA_W range to all ones.
    always_comb begin
        diff_wide = $signed({max_nxt[DATA_W-1], max_nxt}) - $signed({min_nxt[DATA_W-1], min_nxt});
        if (diff_wide[DATA_W]) begin
            diff_nxt = '1;
        end else begin
            diff_nxt = diff_wide[DATA_W-1:0];
        end
    end
`else
    // Unsigned compares against the running extremes.
    assign gt_max = rd_data > max_q;
    assign lt_min = rd_data < min_q;

    // max >= min by construction, so a plain DATA_W subtraction never wraps.
    always_comb begin
        diff_nxt = max_nxt - min_nxt;
    end
`endif

    // Status outputs decode straight from the state register, so reset
    // clears them at once without extra flops.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Next-state, next-address and next-extreme logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch to hold it.
        state_nxt = state;
        addr_nxt  = rd_addr;
        max_nxt   = max_q;
        min_nxt   = min_q;
        case (state)
            S_IDLE: begin
                addr_nxt = '0;
                if (start) begin
                    state_nxt = S_FIRST;
                end
            end
            S_FIRST: begin
                // Element 0 seeds both extremes unconditionally.
                max_nxt = rd_data;
                min_nxt = rd_data;
                if (len_q == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    addr_nxt  = ADDR_W'(1);
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                // Strict compares: equal values leave the extremes untouched.
                if (gt_max) begin
                    max_nxt = rd_data;
                end
                if (lt_min) begin
                    min_nxt = rd_data;
                end
                // Stop on the last index instead of incrementing, so the
                // address never passes len_q and never wraps at len = all ones.
                if (rd_addr == len_q) begin
                    state_nxt = S_DONE;
                end else begin
                    addr_nxt = rd_addr + ADDR_W'(1);
                end
            end
            S_DONE: begin
                addr_nxt  = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                addr_nxt  = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, address and extreme registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rd_addr <= '0;
            max_q   <= '0;
            min_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state   <= state_nxt;
            rd_addr <= addr_nxt;
            max_q   <= max_nxt;
            min_q   <= min_nxt;
        end
    end

    // Capture the scan length only when a start is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
        end else if (state == S_IDLE && start) begin
            len_q <= len;
        end
    end

    // The difference is taken from the final extremes on the edge entering
    // DONE, so it is valid in the same cycle done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
        end else if (state_nxt == S_DONE) begin
            diff_q <= diff_nxt;
        end
    end

endmodule

// File: tb/tb_mmd_minmax_scan.sv
// Self-checking bench for mmd_minmax_scan: table-driven scans plus directed
// sequences for a held start and a reset in mid-scan.
module tb_mmd_minmax_scan;

    localparam int DATA_W = 9;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] diff_q;

    logic [15:0][DATA_W-1:0] mem;

    int checks = 0;
    int errors = 0;

    mmd_minmax_scan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .len     (len),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .max_q   (max_q),
        .min_q   (min_q),
        .diff_q  (diff_q)
    );

    // Combinational store read, as the block expects.
    assign rd_data = mem[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                   name;
        logic [ADDR_W-1:0]       len;
        logic [15:0][DATA_W-1:0] store;
        int                      exp_max;
        int                      exp_min;
        int                      exp_diff;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse start at a falling edge (cycle 0) and observe every following
    // cycle at the falling edge until two cycles past done or the budget ends.
    task automatic run_scan(input logic [ADDR_W-1:0] l, output int done_cyc,
                            output int busy_cnt, output int done_cnt,
                            output int peak, output int diff_at_done);
        done_cyc     = -1;
        busy_cnt     = 0;
        done_cnt     = 0;
        peak         = 0;
        diff_at_done = -1;
        len   = l;
        start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (int'(rd_addr) > peak) peak = int'(rd_addr);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    diff_at_done = int'(diff_q);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
    endtask

    initial begin
        int done_cyc, busy_cnt, done_cnt, peak, diff_at_done;
        int first_done, second_done, n_done, waited;

        // ---- vector table ----
        vecs[0].name = "basic";   vecs[0].len = 4'd3;  vecs[0].store = '0;
        vecs[0].store[0] = 9'd10; vecs[0].store[1] = 9'd3;
        vecs[0].store[2] = 9'd200; vecs[0].store[3] = 9'd3;
        vecs[0].exp_max = 200; vecs[0].exp_min = 3; vecs[0].exp_diff = 197;

        vecs[1].name = "len0";    vecs[1].len = 4'd0;  vecs[1].store = '0;
        vecs[1].store[0] = 9'd77; vecs[1].store[1] = 9'd500;
        vecs[1].exp_max = 77; vecs[1].exp_min = 77; vecs[1].exp_diff = 0;

        vecs[2].name = "full16";  vecs[2].len = 4'd15;
        for (int i = 0; i < 16; i++) vecs[2].store[i] = DATA_W'(i);
        vecs[2].store[15] = 9'd511; vecs[2].store[7] = 9'd0;
        vecs[2].exp_max = 511; vecs[2].exp_min = 0; vecs[2].exp_diff = 511;

        vecs[3].name = "ties";    vecs[3].len = 4'd4;  vecs[3].store = '0;
        vecs[3].store[0] = 9'd50; vecs[3].store[1] = 9'd40;
        vecs[3].store[2] = 9'd60; vecs[3].store[3] = 9'd40;
        vecs[3].store[4] = 9'd60;
        vecs[3].exp_max = 60; vecs[3].exp_min = 40; vecs[3].exp_diff = 20;

        vecs[4].name = "neg1";    vecs[4].len = 4'd1;  vecs[4].store = '0;
        vecs[4].store[0] = 9'h1FF; vecs[4].store[1] = 9'd5;
`ifdef MMD_SIGNED_EN
        vecs[4].exp_max = 5; vecs[4].exp_min = 511; vecs[4].exp_diff = 6;
`else
        vecs[4].exp_max = 511; vecs[4].exp_min = 5; vecs[4].exp_diff = 506;
`endif

        vecs[5].name = "desc";    vecs[5].len = 4'd5;  vecs[5].store = '0;
        vecs[5].store[0] = 9'd90; vecs[5].store[1] = 9'd80;
        vecs[5].store[2] = 9'd70; vecs[5].store[3] = 9'd60;
        vecs[5].store[4] = 9'd50; vecs[5].store[5] = 9'd45;
        vecs[5].store[6] = 9'd1;
        vecs[5].exp_max = 90; vecs[5].exp_min = 45; vecs[5].exp_diff = 45;

        // ---- reset state ----
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        mem   = '0;
        repeat (2) @(negedge clk);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_max",     int'(max_q),   0);
        check("rst_min",     int'(min_q),   0);
        check("rst_diff",    int'(diff_q),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- table-driven scans ----
        for (int v = 0; v < 6; v++) begin
            mem = vecs[v].store;
            run_scan(vecs[v].len, done_cyc, busy_cnt, done_cnt, peak, diff_at_done);
            check({vecs[v].name, "_done_cycle"}, done_cyc, int'(vecs[v].len) + 2);
            check({vecs[v].name, "_busy_cycles"}, busy_cnt, int'(vecs[v].len) + 2);
            check({vecs[v].name, "_done_pulses"}, done_cnt, 1);
            check({vecs[v].name, "_peak_addr"}, peak, int'(vecs[v].len));
            check({vecs[v].name, "_diff_at_done"}, diff_at_done, vecs[v].exp_diff);
            check({vecs[v].name, "_max"}, int'(max_q), vecs[v].exp_max);
            check({vecs[v].name, "_min"}, int'(min_q), vecs[v].exp_min);
            check({vecs[v].name, "_diff"}, int'(diff_q), vecs[v].exp_diff);
            check({vecs[v].name, "_idle_addr"}, int'(rd_addr), 0);
        end

        // ---- start held high across a len=2 scan ----
        mem = '0;
        mem[0] = 9'd4; mem[1] = 9'd9; mem[2] = 9'd1;
        len   = 4'd2;
        start = 1'b1;
        first_done  = -1;
        second_done = -1;
        n_done      = 0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
                else if (second_done < 0) second_done = cyc;
            end
        end
        start = 1'b0;
        check("hold_first_done", first_done, 4);
        check("hold_second_done", second_done, 9);
        check("hold_done_count", n_done, 2);
        waited = 0;
        while (busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("hold_returns_idle", int'(busy), 0);
        check("hold_max", int'(max_q), 9);
        check("hold_min", int'(min_q), 1);
        check("hold_diff", int'(diff_q), 8);

        // ---- reset in mid-scan of a len=7 scan ----
        for (int i = 0; i < 8; i++) mem[i] = DATA_W'(30 + 10 * i);
        mem[3] = 9'd5;
        len   = 4'd7;
        start = 1'b1;
        @(negedge clk);               // cycle 1, FIRST
        start = 1'b0;
        @(negedge clk);               // cycle 2
        @(negedge clk);               // cycle 3, SCAN
        check("mid_busy_before_rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_addr", int'(rd_addr), 0);
        check("mid_rst_busy",    int'(busy),    0);
        check("mid_rst_done",    int'(done),    0);
        check("mid_rst_max",     int'(max_q),   0);
        check("mid_rst_min",     int'(min_q),   0);
        check("mid_rst_diff",    int'(diff_q),  0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid_rst_no_done", n_done, 0);

        // Fresh scan after release: elements 30,40,50,5,70,80,90,100.
        run_scan(4'd7, done_cyc, busy_cnt, done_cnt, peak, diff_at_done);
        check("post_rst_done_cycle", done_cyc, 9);
        check("post_rst_done_pulses", done_cnt, 1);
        check("post_rst_max", int'(max_q), 100);
        check("post_rst_min", int'(min_q), 5);
        check("post_rst_diff", int'(diff_q), 95);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
